// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: runs a full AES-128 block by iterating one shared round datapath.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_LAT    = 2
) (
  input  logic         clk,
  input  logic         RST_N,
  input  logic         START,
  input  logic         ABORT,
  input  logic [127:0] PLAIN_TEXT,
  input  logic [127:0] CIPHER_KEY,
  output logic         READY,
  output logic         BUSY,
  output logic         DONE,
  output logic [127:0] CIPHER_TEXT,
  output logic [3:0]   RND_NUM,
  output logic [127:0] RND_DATA,
  output logic [127:0] RND_KEY,
  output logic         RND_FINAL,
  input  logic [127:0] RND_OUT_DATA,
  input  logic [127:0] RND_OUT_KEY
);
  typedef enum logic {IDLE, RUN} st_e;
  st_e          st_q, st_d;
  logic [127:0] state_q, state_d, key_q, key_d, ct_q, ct_d;
  logic [3:0]   rnd_q, rnd_d, cnt_q, cnt_d;
  logic         done_q, done_d, last, at_lat;
  assign last   = rnd_q == 4'(NUM_ROUNDS);
  assign at_lat = cnt_q == 4'(RND_LAT);
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    ct_d    = ct_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (st_q == IDLE) begin
      if (START && !ABORT) begin
        state_d = PLAIN_TEXT ^ CIPHER_KEY;
        key_d   = CIPHER_KEY;
        rnd_d   = 4'd1;
        cnt_d   = 4'd0;
        st_d    = RUN;
      end
    end else if (ABORT) begin
      st_d  = IDLE;
      rnd_d = 4'd0;
      cnt_d = 4'd0;
    end else if (!at_lat) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!last) begin
      state_d = RND_OUT_DATA;
      key_d   = RND_OUT_KEY;
      rnd_d   = rnd_q + 4'd1;
      cnt_d   = 4'd0;
    end else begin
      ct_d   = RND_OUT_DATA;
      done_d = 1'b1;
      st_d   = IDLE;
    end
  end
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      rnd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign READY       = st_q == IDLE;
  assign BUSY        = st_q == RUN;
  assign DONE        = done_q;
  assign CIPHER_TEXT = ct_q;
  assign RND_NUM     = rnd_q;
  assign RND_DATA    = state_q;
  assign RND_KEY     = key_q;
  assign RND_FINAL   = (st_q == RUN) && last;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: drives the sequencer against a behavioural 2-cycle AES round datapath.
module tb_aes_round_sequencer;
  logic         clk = 1'b0, RST_N = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic [127:0] PLAIN_TEXT = '0, CIPHER_KEY = '0;
  logic         READY, BUSY, DONE, RND_FINAL;
  logic [127:0] CIPHER_TEXT, RND_DATA, RND_KEY, RND_OUT_DATA, RND_OUT_KEY;
  logic [3:0]   RND_NUM;
  logic [255:0] p1, p2;
  int           n_cmp = 0, n_bad = 0;
  logic [127:0] last_ct = '0;
  aes_round_sequencer dut (
    .clk(clk), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .PLAIN_TEXT(PLAIN_TEXT), .CIPHER_KEY(CIPHER_KEY),
    .READY(READY), .BUSY(BUSY), .DONE(DONE), .CIPHER_TEXT(CIPHER_TEXT),
    .RND_NUM(RND_NUM), .RND_DATA(RND_DATA), .RND_KEY(RND_KEY), .RND_FINAL(RND_FINAL),
    .RND_OUT_DATA(RND_OUT_DATA), .RND_OUT_KEY(RND_OUT_KEY)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = xt(a);
    end
    return r;
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r = 8'h01, p = x, e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gm(r, p);
      p = gm(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  // one AES round plus key-schedule step; returns {data, next key}
  function automatic logic [255:0] aes_rnd(input logic [127:0] d, input logic [127:0] k,
                                           input logic [3:0] r, input logic fin);
    logic [7:0]   b[16], t[16], rc, a0, a1, a2, a3;
    logic [31:0]  w[4], tw;
    logic [127:0] nk, nd;
    rc = 8'h01;
    for (int i = 1; i < int'(r); i++) rc = xt(rc);
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    tw = {sb(w[3][23:16]), sb(w[3][15:8]), sb(w[3][7:0]), sb(w[3][31:24])} ^ {rc, 24'h0};
    w[0] ^= tw; w[1] ^= w[0]; w[2] ^= w[1]; w[3] ^= w[2];
    nk = {w[0], w[1], w[2], w[3]};
    for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++) t[q+4*c] = sb(b[q+4*((c+q)%4)]);
    if (!fin)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
        t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end
    for (int i = 0; i < 16; i++) nd[127-8*i -: 8] = t[i] ^ nk[127-8*i -: 8];
    return {nd, nk};
  endfunction
  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s = pt ^ k, kk = k;
    logic [255:0] o;
    for (int r = 1; r <= 10; r++) begin
      o = aes_rnd(s, kk, 4'(r), r == 10);
      s = o[255:128];
      kk = o[127:0];
    end
    return s;
  endfunction
  always @(posedge clk) begin
    p1 <= aes_rnd(RND_DATA, RND_KEY, RND_NUM, RND_FINAL);
    p2 <= p1;
  end
  assign RND_OUT_DATA = p2[255:128];
  assign RND_OUT_KEY  = p2[127:0];
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic start_blk(input logic [127:0] pt, input logic [127:0] k);
    @(negedge clk);
    PLAIN_TEXT = pt; CIPHER_KEY = k; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
  endtask
  task automatic blk(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
    logic [127:0] pd;
    int dn = 0;
    start_blk(pt, k);
    chk("busy0", 128'(BUSY), 128'(1));
    chk("ready0", 128'(READY), 128'(0));
    chk("data0", RND_DATA, pt ^ k);
    chk("key0", RND_KEY, k);
    pd = RND_DATA;
    for (int j = 0; j < 30; j++) begin
      if (j > 0) @(negedge clk);
      chk("rnd_num", 128'(RND_NUM), 128'(j / 3 + 1));
      chk("rnd_final", 128'(RND_FINAL), 128'(j >= 27));
      if (j % 3 != 0) chk("data_hold", RND_DATA, pd);
      pd = RND_DATA;
      dn += int'(DONE);
    end
    chk("early_done", 128'(dn), 128'(0));
    @(negedge clk);
    chk("done", 128'(DONE), 128'(1));
    chk("cipher", CIPHER_TEXT, exp);
    chk("ready_end", 128'(READY), 128'(1));
    chk("final_end", 128'(RND_FINAL), 128'(0));
    @(negedge clk);
    chk("done_pulse", 128'(DONE), 128'(0));
    last_ct = exp;
  endtask
  initial begin
    logic [127:0] pa, ka, pb, kb;
    int dn, kd;
    #12;
    chk("rst_ready", 128'(READY), 128'(1));
    chk("rst_busy", 128'(BUSY), 128'(0));
    chk("rst_done", 128'(DONE), 128'(0));
    chk("rst_final", 128'(RND_FINAL), 128'(0));
    chk("rst_ct", CIPHER_TEXT, '0);
    chk("rst_num", 128'(RND_NUM), '0);
    chk("rst_data", RND_DATA, '0);
    chk("rst_key", RND_KEY, '0);
    @(negedge clk);
    RST_N = 1'b1;
    blk(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int i = 0; i < 4; i++) begin
      pa = rnd128(); ka = rnd128();
      blk(pa, ka, enc(pa, ka));
    end
    pa = rnd128(); ka = rnd128();
    start_blk(pa, ka);
    repeat (12) @(negedge clk);
    chk("abort_rnd", 128'(RND_NUM), 128'(5));
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    chk("abort_ready", 128'(READY), 128'(1));
    chk("abort_busy", 128'(BUSY), 128'(0));
    chk("abort_num", 128'(RND_NUM), '0);
    chk("abort_done", 128'(DONE), 128'(0));
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(DONE);
    end
    chk("abort_nodone", 128'(dn), '0);
    chk("abort_ct", CIPHER_TEXT, last_ct);
    START = 1'b1; ABORT = 1'b1;
    @(negedge clk);
    START = 1'b0; ABORT = 1'b0;
    chk("sa_ready", 128'(READY), 128'(1));
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    chk("ai_ready", 128'(READY), 128'(1));
    pa = rnd128(); ka = rnd128(); pb = rnd128();
    start_blk(pa, ka);
    dn = 0; kd = -1;
    for (int j = 0; j <= 45; j++) begin
      if (j > 0) @(negedge clk);
      START = (j == 6);
      if (j == 6) PLAIN_TEXT = pb;
      if (DONE) begin
        dn++;
        if (kd < 0) kd = j;
      end
    end
    START = 1'b0;
    chk("busy_start_cnt", 128'(dn), 128'(1));
    chk("busy_start_at", 128'(kd), 128'(30));
    chk("busy_start_ct", CIPHER_TEXT, enc(pa, ka));
    pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
    start_blk(pa, ka);
    repeat (30) @(negedge clk);
    chk("b2b_done1", 128'(DONE), 128'(1));
    chk("b2b_ct1", CIPHER_TEXT, enc(pa, ka));
    PLAIN_TEXT = pb; CIPHER_KEY = kb; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    chk("b2b_busy", 128'(BUSY), 128'(1));
    chk("b2b_data0", RND_DATA, pb ^ kb);
    chk("b2b_single", 128'(DONE), 128'(0));
    dn = 0;
    repeat (29) begin
      @(negedge clk);
      dn += int'(DONE);
    end
    chk("b2b_early", 128'(dn), '0);
    @(negedge clk);
    chk("b2b_done2", 128'(DONE), 128'(1));
    chk("b2b_ct2", CIPHER_TEXT, enc(pb, kb));
    pa = rnd128(); ka = rnd128();
    start_blk(pa, ka);
    repeat (18) @(negedge clk);
    chk("mrst_rnd", 128'(RND_NUM), 128'(7));
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_ready", 128'(READY), 128'(1));
    chk("mrst_busy", 128'(BUSY), 128'(0));
    chk("mrst_done", 128'(DONE), 128'(0));
    chk("mrst_final", 128'(RND_FINAL), 128'(0));
    chk("mrst_ct", CIPHER_TEXT, '0);
    chk("mrst_num", 128'(RND_NUM), '0);
    chk("mrst_data", RND_DATA, '0);
    chk("mrst_key", RND_KEY, '0);
    @(negedge clk);
    RST_N = 1'b1;
    pa = rnd128(); ka = rnd128();
    blk(pa, ka, enc(pa, ka));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
